// File: rtl/aes_inv_cipher.sv
// Iterative AES-256 ECB decryptor: forward key expansion, then one inverse round per clock.
// Latency 28 clocks from capture to done_o (15 on a key-cache hit when AES_DEC_KEY_CACHE_EN is defined).
// Backpressure: inputs ignored while busy_o; result held with done_o until en_i drops.
module aes_inv_cipher #(
  parameter int KEY_W = 256,
  parameter int NR    = 14
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [127:0]     ciphertext_i,
  input  logic [KEY_W-1:0] key_i,
  output logic [127:0]     plaintext_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [2:0] {S_IDLE, S_KEYEXP, S_INIT, S_ROUND, S_FINAL, S_DONE} state_t;

  state_t       cur, nxt;
  logic [127:0] st;
  logic [127:0] rk [0:NR];
  logic [3:0]   rnd;
  logic [3:0]   kidx;
  logic [7:0]   rcon;
  logic         cache_hit;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r, p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Byte k of the block sits at bits [127-8k -: 8]; row = k%4, column = k/4.
  function automatic logic [127:0] inv_sr_sb(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = inv_sbox(s[127-8*(r+4*((c+4-r)%4)) -: 8]);
    return o;
  endfunction

  // k selects the xtime terms: 9 = x8+1, b = x8+x2+1, d = x8+x4+1, e = x8+x4+x2.
  function automatic logic [7:0] mulk(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xt(a);
    x4 = xt(x2);
    x8 = xt(x4);
    return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[0] ? a : 8'h00);
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {
        mulk(a0, 4'he) ^ mulk(a1, 4'hb) ^ mulk(a2, 4'hd) ^ mulk(a3, 4'h9),
        mulk(a0, 4'h9) ^ mulk(a1, 4'he) ^ mulk(a2, 4'hb) ^ mulk(a3, 4'hd),
        mulk(a0, 4'hd) ^ mulk(a1, 4'h9) ^ mulk(a2, 4'he) ^ mulk(a3, 4'hb),
        mulk(a0, 4'hb) ^ mulk(a1, 4'hd) ^ mulk(a2, 4'h9) ^ mulk(a3, 4'he)};
    end
    return o;
  endfunction

  // One AES-256 schedule step: rk[i] from rk[i-2] and rk[i-1].
  function automatic logic [127:0] next_rk(input logic [127:0] p2, input logic [127:0] p1,
                                           input logic even, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = even ? (sub_word({p1[23:0], p1[31:24]}) ^ {rc, 24'h0}) : sub_word(p1[31:0]);
    n0 = p2[127:96] ^ t;
    n1 = p2[95:64] ^ n0;
    n2 = p2[63:32] ^ n1;
    n3 = p2[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  assign rcon = 8'h01 << (kidx[3:1] - 3'd1);

`ifdef AES_DEC_KEY_CACHE_EN
  logic cache_valid;
  assign cache_hit = cache_valid && (key_i == {rk[0], rk[1]});
`else
  assign cache_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) cur <= S_IDLE;
    else        cur <= nxt;
  end

  always_comb begin
    nxt    = cur;
    busy_o = 1'b0;
    done_o = 1'b0;
    case (cur)
      S_IDLE:   if (en_i) nxt = cache_hit ? S_INIT : S_KEYEXP;
      S_KEYEXP: begin
        busy_o = 1'b1;
        if (kidx == 4'(NR)) nxt = S_INIT;
      end
      S_INIT:   begin
        busy_o = 1'b1;
        nxt    = S_ROUND;
      end
      S_ROUND:  begin
        busy_o = 1'b1;
        if (rnd == 4'd1) nxt = S_FINAL;
      end
      S_FINAL:  begin
        busy_o = 1'b1;
        nxt    = S_DONE;
      end
      S_DONE:   begin
        done_o = 1'b1;
        if (!en_i) nxt = S_IDLE;
      end
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      st          <= '0;
      plaintext_o <= '0;
      rnd         <= '0;
      kidx        <= '0;
      for (int i = 0; i <= NR; i++) rk[i] <= '0;
`ifdef AES_DEC_KEY_CACHE_EN
      cache_valid <= 1'b0;
`endif
    end else begin
      case (cur)
        S_IDLE: if (en_i) begin
          st    <= ciphertext_i;
          rk[0] <= key_i[255:128];
          rk[1] <= key_i[127:0];
          kidx  <= 4'd2;
`ifdef AES_DEC_KEY_CACHE_EN
          cache_valid <= cache_hit;
`endif
        end
        S_KEYEXP: begin
          rk[kidx] <= next_rk(rk[kidx-4'd2], rk[kidx-4'd1], ~kidx[0], rcon);
          kidx     <= kidx + 4'd1;
`ifdef AES_DEC_KEY_CACHE_EN
          if (kidx == 4'(NR)) cache_valid <= 1'b1;
`endif
        end
        S_INIT: begin
          st  <= st ^ rk[NR];
          rnd <= 4'(NR - 1);
        end
        S_ROUND: begin
          st  <= inv_mix(inv_sr_sb(st) ^ rk[rnd]);
          rnd <= rnd - 4'd1;
        end
        S_FINAL: plaintext_o <= inv_sr_sb(st) ^ rk[0];
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Bench for aes_inv_cipher: table-driven AES-256 decrypt model, per-cycle output monitor, directed ops.
// Build with +define+AES_DEC_KEY_CACHE_EN to expect the short latency on repeated keys.
module tb_aes_inv_cipher;

  logic         clk_i = 1'b0;
  logic         rst_n = 1'b0;
  logic         en_i = 1'b0;
  logic [127:0] ciphertext_i = '0;
  logic [255:0] key_i = '0;
  logic [127:0] plaintext_o;
  logic         busy_o;
  logic         done_o;

  aes_inv_cipher dut (
    .clk_i(clk_i), .rst_n(rst_n), .en_i(en_i), .ciphertext_i(ciphertext_i),
    .key_i(key_i), .plaintext_o(plaintext_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

`ifdef AES_DEC_KEY_CACHE_EN
  localparam int HIT_LAT = 15;
`else
  localparam int HIT_LAT = 28;
`endif

  localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FIPS_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] TEAM_KEY = {8{32'h74657374}};
  localparam logic [127:0] TEAM_CT  = 128'h4419ce8172f99fa38dc6119260edb3f8;
  localparam logic [127:0] TEAM_PT  = 128'h616c656e6b72757468616c656e6b7275;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0]   sbox_t  [256];
  logic [7:0]   isbox_t [256];
  logic [127:0] exp_pt = '0;
  bit           mon_en = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  // S-box from a brute-force inverse search plus the bitwise affine map.
  task automatic build_tables();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_t[a]  = s;
      isbox_t[s] = 8'(a);
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
  endfunction

  function automatic logic [127:0] model_dec(input logic [127:0] ct, input logic [255:0] key);
    logic [31:0]  w [60];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      tmp = w[i-1];
      if (i % 8 == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-8] ^ tmp;
    end
    for (int k = 0; k < 16; k++) s[k] = ct[127-8*k -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[4*c+r] ^= w[56+c][31-8*r -: 8];
    for (int rd = 13; rd >= 0; rd--) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+4-r)%4)+r];
      for (int k = 0; k < 16; k++) s[k] = isbox_t[t[k]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] ^= w[4*rd+c][31-8*r -: 8];
      if (rd > 0) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
          s[4*c+1] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
          s[4*c+2] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
          s[4*c+3] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
      end
    end
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = s[k];
    return o;
  endfunction

  // Whenever a result is presented it must match the model, and busy/done stay exclusive.
  always @(negedge clk_i) begin
    if (mon_en && rst_n) begin
      check("mon_busy_done_excl", 256'(busy_o & done_o), 256'(0));
      if (done_o) check("mon_pt", 256'(plaintext_o), 256'(exp_pt));
    end
  end

  task automatic run_op(input string tag, input logic [127:0] ct, input logic [255:0] key,
                        input logic [127:0] exp, input int exp_lat, input bit churn, input bit drop_mid);
    int lat;
    bit got;
    lat = 0;
    got = 1'b0;
    @(negedge clk_i);
    ciphertext_i = ct;
    key_i        = key;
    en_i         = 1'b1;
    exp_pt       = exp;
    @(posedge clk_i); #1;
    check({tag, "_busy_after_capture"}, 256'(busy_o), 256'(1));
    for (int n = 1; n <= 60 && !got; n++) begin
      if (churn && busy_o) begin
        ciphertext_i = {$urandom, $urandom, $urandom, $urandom};
        key_i        = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      end
      if (drop_mid && n == 5) en_i = 1'b0;
      @(posedge clk_i); #1;
      if (done_o) begin
        got = 1'b1;
        lat = n;
      end
    end
    check({tag, "_latency"}, 256'(lat), 256'(exp_lat));
    check({tag, "_pt"}, 256'(plaintext_o), 256'(exp));
    check({tag, "_busy_at_done"}, 256'(busy_o), 256'(0));
  endtask

  task automatic release_en(input string tag);
    @(negedge clk_i);
    en_i = 1'b0;
    @(posedge clk_i); #1;
    check({tag, "_rel_done"}, 256'(done_o), 256'(0));
    check({tag, "_rel_busy"}, 256'(busy_o), 256'(0));
    check({tag, "_rel_pt_held"}, 256'(plaintext_o), 256'(exp_pt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    build_tables();
    check("model_sbox_00", 256'(sbox_t[8'h00]), 256'(8'h63));
    check("model_sbox_53", 256'(sbox_t[8'h53]), 256'(8'hed));
    check("model_isbox_16", 256'(isbox_t[8'h16]), 256'(8'hff));
    check("model_fips", 256'(model_dec(FIPS_CT, FIPS_KEY)), 256'(FIPS_PT));
    check("model_team", 256'(model_dec(TEAM_CT, TEAM_KEY)), 256'(TEAM_PT));

    #22;
    check("rst_pt", 256'(plaintext_o), 256'(0));
    check("rst_busy", 256'(busy_o), 256'(0));
    check("rst_done", 256'(done_o), 256'(0));
    @(negedge clk_i);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk_i); #1;
    check("idle_done", 256'(done_o), 256'(0));

    run_op("fips", FIPS_CT, FIPS_KEY, FIPS_PT, 28, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      check("hold_done", 256'(done_o), 256'(1));
      check("hold_busy", 256'(busy_o), 256'(0));
    end
    release_en("fips");

    run_op("team_churn", TEAM_CT, TEAM_KEY, TEAM_PT, 28, 1'b1, 1'b0);
    release_en("team_churn");

    // Abort at E10 of an operation; outputs must clear without waiting for a clock.
    @(negedge clk_i);
    ciphertext_i = FIPS_CT;
    key_i        = FIPS_KEY;
    en_i         = 1'b1;
    @(posedge clk_i);
    repeat (10) @(posedge clk_i);
    #2 rst_n = 1'b0;
    #1;
    check("abort_pt", 256'(plaintext_o), 256'(0));
    check("abort_busy", 256'(busy_o), 256'(0));
    check("abort_done", 256'(done_o), 256'(0));
    @(negedge clk_i);
    en_i = 1'b0;
    @(negedge clk_i);
    rst_n = 1'b1;

    run_op("fips_after_rst", FIPS_CT, FIPS_KEY, FIPS_PT, 28, 1'b0, 1'b0);
    release_en("fips_after_rst");

    run_op("same_key", 128'h0123456789abcdeffedcba9876543210, FIPS_KEY,
           model_dec(128'h0123456789abcdeffedcba9876543210, FIPS_KEY), HIT_LAT, 1'b0, 1'b0);
    release_en("same_key");

    run_op("new_key", TEAM_CT, TEAM_KEY, TEAM_PT, 28, 1'b0, 1'b0);
    release_en("new_key");

    // en_i dropped mid-operation: op completes, done lasts exactly one cycle.
    run_op("drop_mid", TEAM_CT, TEAM_KEY, TEAM_PT, HIT_LAT, 1'b0, 1'b1);
    @(posedge clk_i); #1;
    check("drop_mid_done_clear", 256'(done_o), 256'(0));
    check("drop_mid_busy", 256'(busy_o), 256'(0));
    check("drop_mid_pt_held", 256'(plaintext_o), 256'(TEAM_PT));
    repeat (3) @(posedge clk_i);
    #1;
    check("drop_mid_no_restart", 256'(busy_o), 256'(0));

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
